user_pattern_seq: RTL

USER_PATTERN_SEQ -- requirements
Module: user_pattern_seq

---
 rtl/user_pattern_pkg.sv | 15 +
 rtl/user_pattern_regs.sv | 48 ++++
 rtl/user_pattern_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/user_pattern_pkg.sv
// Shared types and constants for the user pattern sequencer.
// Holds the sequencer state enum plus test-mode and run-mode codes.
package user_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [3:0] TEST_MODE_USER = 4'b1000;
  localparam logic       MODE_SINGLE    = 1'b1;
  localparam logic       MODE_CONT      = 1'b0;

endpackage

// File: rtl/user_pattern_regs.sv
// Pattern bank: N_PAT x DATA_W registers, one write port, N_CH comb reads.
// Ports: clk, reset (sync, high), wr_en/wr_idx/wr_data, rd_idx, rd_data.
module user_pattern_regs #(
  parameter int DATA_W = 16,
  parameter int N_PAT  = 4,
  parameter int N_CH   = 2,
  parameter int IW     = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_idx,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [N_CH*IW-1:0]     rd_idx,
  output logic [N_CH*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] bank_q [N_PAT];
  logic [DATA_W-1:0] bank_d [N_PAT];

  always_comb begin
    bank_d = bank_q;
    if (wr_en && (int'(wr_idx) < N_PAT)) begin
      bank_d[wr_idx] = wr_data;
    end
  end

  // Reads see the registered value, so a same-edge
  // write is only visible on the next visit.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(rd_idx[k*IW +: IW]) < N_PAT) begin
        rd_data[k*DATA_W +: DATA_W] =
          bank_q[rd_idx[k*IW +: IW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '{default: '0};
    end else begin
      bank_q <= bank_d;
    end
  end

endmodule

// File: rtl/user_pattern_seq.sv
// User pattern sequencer: replays a register bank on N_CH rotated channels.
// Ports: clk, reset, select_mode, mode_control, pat_len, pat_wr_*, out_*, seq_done.
module user_pattern_seq
  import user_pattern_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_PAT  = 4,
  parameter int N_CH   = 2,
  parameter int LW     = $clog2(N_PAT + 1),
  parameter int IW     = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             select_mode,
  input  logic                   mode_control,
  input  logic [LW-1:0]          pat_len,
  input  logic                   pat_wr_en,
  input  logic [IW-1:0]          pat_wr_idx,
  input  logic [DATA_W-1:0]      pat_wr_data,
  output logic [N_CH*DATA_W-1:0] out_pattern,
  output logic                   out_valid,
  output logic                   seq_done
);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [LW-1:0]           len_q, len_d;
  logic [N_CH*DATA_W-1:0]  out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [N_CH*IW-1:0]      rd_idx;
  logic [N_CH*DATA_W-1:0]  rd_data;
  logic                    last;

  function automatic logic [LW-1:0] clamp_len(
    input logic [LW-1:0] l
  );
    if (l == '0) return LW'(1);
    if (int'(l) > N_PAT) return LW'(N_PAT);
    return l;
  endfunction

  user_pattern_regs #(
    .DATA_W (DATA_W),
    .N_PAT  (N_PAT),
    .N_CH   (N_CH),
    .IW     (IW)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pat_wr_en),
    .wr_idx  (pat_wr_idx),
    .wr_data (pat_wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Channel k reads (idx+k) mod len_r; len_r is never 0.
  always_comb begin
    rd_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      rd_idx[k*IW +: IW] =
        IW'((int'(idx_q) + k) % int'(len_q));
    end
  end

  assign last = (int'(idx_q) == int'(len_q) - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (select_mode != TEST_MODE_USER) begin
      state_d = ST_IDLE;
      out_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          idx_d   = '0;
          len_d   = clamp_len(pat_len);
          out_d   = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
        ST_RUN: begin
          out_d   = rd_data;
          valid_d = 1'b1;
          done_d  = 1'b0;
          if (last) begin
            idx_d = '0;
            len_d = clamp_len(pat_len);
            if (mode_control == MODE_SINGLE) begin
              state_d = ST_HOLD;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_HOLD: begin
          out_d   = '0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          if (mode_control == MODE_CONT) begin
            state_d = ST_RUN;
            idx_d   = '0;
            len_d   = clamp_len(pat_len);
            done_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= LW'(1);
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign out_pattern = out_q;
  assign out_valid   = valid_q;
  assign seq_done    = done_q;

endmodule
